// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change path.
// Contents:
//   coin_t     - 2-bit coin code (00=1, 01=5, 10=10, 11=20 units)
//   state_t    - change_dispenser FSM states
//   fault_t    - latched fault codes
//   MAX_CHANGE_DEFAULT - default largest accepted change value
//   denom()    - coin code to denomination value in money units
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_5  = 2'b01,
    COIN_10 = 2'b10,
    COIN_20 = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_SHORT   = 2'b01,
    FAULT_TIMEOUT = 2'b10,
    FAULT_RANGE   = 2'b11
  } fault_t;

  localparam int MAX_CHANGE_DEFAULT = 40;

  // Denomination table: value of one coin of the given code.
  function automatic logic [7:0] denom(input coin_t c);
    logic [7:0] v;
    case (c)
      COIN_1:  v = 8'd1;
      COIN_5:  v = 8'd5;
      COIN_10: v = 8'd10;
      COIN_20: v = 8'd20;
      default: v = 8'd1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_picker.sv
// Combinational coin selector: returns the largest denomination that does
// not exceed the amount still owed and whose hopper is not empty.
// Ports:
//   remaining  in  8  amount still owed
//   coin_empty in  4  hopper-empty flags indexed by coin code
//   coin_code  out 2  chosen coin code (valid when found=1)
//   found      out 1  an eligible coin exists
module coin_picker
  import vm_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [3:0] coin_empty,
  output coin_t      coin_code,
  output logic       found
);

  // Scan from the largest code down; the first eligible hit wins.
  always_comb begin
    coin_code = COIN_1;
    found     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && !coin_empty[i] && (denom(coin_t'(2'(i))) <= remaining)) begin
        coin_code = coin_t'(2'(i));
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change amount one coin at a time through a
// request/acknowledge handshake with the coin hopper, greedy largest-first.
// Ports:
//   clk           in  1  clock, rising edge
//   reset_n       in  1  asynchronous active-low reset
//   change_valid  in  1  one-cycle pulse qualifying change_in
//   change_in     in  8  amount to pay out
//   coin_empty    in  4  hopper-empty flags indexed by coin code
//   coin_ack      in  1  hopper ejected the requested coin
//   fault_clr     in  1  clears a latched fault
//   coin_req      out 1  request one coin of coin_sel
//   coin_sel      out 2  requested coin code
//   busy          out 1  FSM not idle
//   dispense_done out 1  one-cycle pulse when fully paid
//   remaining     out 8  amount still owed (shortfall after a fault)
//   fault         out 1  latched fault
//   fault_code    out 2  00 none, 01 shortfall, 10 ack timeout, 11 over-range
module change_dispenser
  import vm_pkg::*;
#(
  parameter int MAX_CHANGE  = MAX_CHANGE_DEFAULT,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       change_valid,
  input  logic [7:0] change_in,
  input  logic [3:0] coin_empty,
  input  logic       coin_ack,
  input  logic       fault_clr,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       dispense_done,
  output logic [7:0] remaining,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int              CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0]      MAX_LIMIT = 8'(MAX_CHANGE);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  coin_t            sel_q;
  fault_t           fcode_q;
  coin_t            pick_code;
  logic             pick_found;

  coin_picker u_picker (
    .remaining (remaining),
    .coin_empty(coin_empty),
    .coin_code (pick_code),
    .found     (pick_found)
  );

  assign coin_sel   = sel_q;
  assign fault_code = fcode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      sel_q         <= COIN_1;
      fcode_q       <= FAULT_NONE;
      coin_req      <= 1'b0;
      busy          <= 1'b0;
      dispense_done <= 1'b0;
      remaining     <= '0;
      fault         <= 1'b0;
    end else begin
      dispense_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (change_valid) begin
            busy      <= 1'b1;
            remaining <= change_in;
            if (change_in > MAX_LIMIT) begin
              fault   <= 1'b1;
              fcode_q <= FAULT_RANGE;
              state   <= ST_FAULT;
            end else begin
              state <= ST_SELECT;
            end
          end
        end

        ST_SELECT: begin
          if (remaining == 8'd0) begin
            // Pulse is raised here so it is visible during the DONE cycle.
            dispense_done <= 1'b1;
            state         <= ST_DONE;
          end else if (pick_found) begin
            sel_q    <= pick_code;
            coin_req <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_REQ;
          end else begin
            fault   <= 1'b1;
            fcode_q <= FAULT_SHORT;
            state   <= ST_FAULT;
          end
        end

        ST_REQ: begin
          // Ack is checked first so it wins over a coincident timeout.
          // The picker guaranteed denom(sel_q) <= remaining, so no underflow.
          if (coin_ack) begin
            remaining <= remaining - denom(sel_q);
            coin_req  <= 1'b0;
            state     <= ST_SELECT;
          end else if (wait_cnt == WAIT_LAST) begin
            coin_req <= 1'b0;
            fault    <= 1'b1;
            fcode_q  <= FAULT_TIMEOUT;
            state    <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_FAULT: begin
          if (fault_clr) begin
            fault     <= 1'b0;
            fcode_q   <= FAULT_NONE;
            remaining <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          coin_req <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed transactions push their
// expected coin/done/fault events into a queue; a monitor pops and compares
// each event the DUT presents. A hopper model acknowledges coin requests.
module tb_change_dispenser;

  localparam int EV_COIN  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int kind;
    int code;
    int rem;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       change_valid;
  logic [7:0] change_in;
  logic [3:0] coin_empty;
  logic       coin_ack;
  logic       fault_clr;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       dispense_done;
  logic [7:0] remaining;
  logic       fault;
  logic [1:0] fault_code;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  bit  ack_en    = 1'b1;
  int  ack_delay = 2;
  int  req_hi;

  change_dispenser #(
    .MAX_CHANGE (40),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .change_valid (change_valid),
    .change_in    (change_in),
    .coin_empty   (coin_empty),
    .coin_ack     (coin_ack),
    .fault_clr    (fault_clr),
    .coin_req     (coin_req),
    .coin_sel     (coin_sel),
    .busy         (busy),
    .dispense_done(dispense_done),
    .remaining    (remaining),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int code, input int rem);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.rem  = rem;
    exp_q.push_back(e);
  endtask

  // Compare one observed event against the head of the queue.
  task automatic handle(input int kind, input int code, input int rem);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event", kind * 65536 + code * 256 + rem,
            e.kind * 65536 + e.code * 256 + e.rem);
    end
  endtask

  // Monitor: detects coin request starts, done pulses and fault onsets.
  initial begin
    bit prev_req;
    bit prev_fault;
    prev_req   = 1'b0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (coin_req && !prev_req) handle(EV_COIN, int'(coin_sel), int'(remaining));
        if (dispense_done) handle(EV_DONE, 0, int'(remaining));
        if (fault && !prev_fault) handle(EV_FAULT, int'(fault_code), int'(remaining));
      end
      prev_req   = coin_req;
      prev_fault = fault;
    end
  end

  // Hopper model: acknowledge after coin_req has been high ack_delay cycles.
  initial begin
    int age;
    age      = 0;
    coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      coin_ack = 1'b0;
      if (coin_req && reset_n) begin
        age++;
        if (ack_en && age == ack_delay) coin_ack = 1'b1;
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 hangs", 1);
    $fatal(1);
  end

  task automatic send(input int v);
    @(negedge clk);
    change_valid = 1'b1;
    change_in    = 8'(v);
    @(negedge clk);
    change_valid = 1'b0;
  endtask

  // Advance until idle or faulted, counting cycles with coin_req high.
  task automatic wait_end(input int max);
    int k;
    req_hi = 0;
    for (k = 0; k < max; k++) begin
      if (!busy || fault) break;
      if (coin_req) req_hi++;
      @(negedge clk);
    end
    check("wait_bound", int'(k < max), 1);
  endtask

  task automatic clear_fault();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_fault", int'(fault), 0);
    check("clr_code", int'(fault_code), 0);
    check("clr_remaining", int'(remaining), 0);
    check("clr_busy", int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_coin_req"}, int'(coin_req), 0);
    check({tag, "_coin_sel"}, int'(coin_sel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(dispense_done), 0);
    check({tag, "_remaining"}, int'(remaining), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_fault_code"}, int'(fault_code), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    change_valid = 1'b0;
    change_in    = 8'd0;
    coin_empty   = 4'b0000;
    fault_clr    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // 37 with all hoppers full: 20,10,5,1,1; a stray change_valid is ignored.
    push_ev(EV_COIN, 3, 37);
    push_ev(EV_COIN, 2, 17);
    push_ev(EV_COIN, 1, 7);
    push_ev(EV_COIN, 0, 2);
    push_ev(EV_COIN, 0, 1);
    push_ev(EV_DONE, 0, 0);
    send(37);
    @(negedge clk);
    change_valid = 1'b1;
    change_in    = 8'd99;
    @(negedge clk);
    change_valid = 1'b0;
    wait_end(200);
    check("c37_remaining", int'(remaining), 0);
    check("c37_busy", int'(busy), 0);

    // Zero change: SELECT in cycle N+1, done in N+2, no coin request.
    push_ev(EV_DONE, 0, 0);
    send(0);
    check("zero_busy_n1", int'(busy), 1);
    check("zero_done_n1", int'(dispense_done), 0);
    @(negedge clk);
    check("zero_done_n2", int'(dispense_done), 1);
    check("zero_req_n2", int'(coin_req), 0);
    @(negedge clk);
    check("zero_done_n3", int'(dispense_done), 0);
    check("zero_busy_n3", int'(busy), 0);

    // 30 with the 10 and 20 hoppers empty: six 5-unit coins.
    coin_empty = 4'b1100;
    for (int i = 0; i < 6; i++) push_ev(EV_COIN, 1, 30 - 5 * i);
    push_ev(EV_DONE, 0, 0);
    send(30);
    wait_end(200);
    check("c30_req_cycles", req_hi, 12);

    // 7 with the 1-unit hopper empty: one 5 coin, then shortfall of 2.
    coin_empty = 4'b0001;
    push_ev(EV_COIN, 1, 7);
    push_ev(EV_FAULT, 1, 2);
    send(7);
    wait_end(100);
    check("short_fault", int'(fault), 1);
    check("short_code", int'(fault_code), 1);
    check("short_remaining", int'(remaining), 2);
    check("short_busy", int'(busy), 1);
    clear_fault();
    coin_empty = 4'b0000;

    // 10 with the hopper never acknowledging: timeout after 16 REQ cycles.
    ack_en = 1'b0;
    push_ev(EV_COIN, 2, 10);
    push_ev(EV_FAULT, 2, 10);
    send(10);
    wait_end(100);
    check("tmo_req_cycles", req_hi, 16);
    check("tmo_coin_req", int'(coin_req), 0);
    check("tmo_code", int'(fault_code), 2);
    clear_fault();
    ack_en = 1'b1;

    // 41 is over range: immediate fault 11, no coin request.
    push_ev(EV_FAULT, 3, 41);
    send(41);
    wait_end(20);
    check("range_req_cycles", req_hi, 0);
    check("range_coin_req", int'(coin_req), 0);
    check("range_code", int'(fault_code), 3);
    clear_fault();

    // 40 is the largest accepted value: two 20 coins.
    push_ev(EV_COIN, 3, 40);
    push_ev(EV_COIN, 3, 20);
    push_ev(EV_DONE, 0, 0);
    send(40);
    wait_end(100);
    check("c40_fault", int'(fault), 0);

    // Reset pulsed mid-REQ: outputs clear without a clock edge.
    ack_en = 1'b0;
    push_ev(EV_COIN, 3, 25);
    send(25);
    repeat (3) @(negedge clk);
    check("mid_req_active", int'(coin_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;

    // Next transaction after reset is served normally; no retried coin.
    push_ev(EV_COIN, 1, 6);
    push_ev(EV_COIN, 0, 1);
    push_ev(EV_DONE, 0, 0);
    send(6);
    wait_end(100);
    check("post_rst_remaining", int'(remaining), 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter MAX_CHANGE, default 40, is the largest accepted change value in money units.
REQ-002 Parameter ACK_TIMEOUT, default 16, is the number of cycles coin_req may wait for coin_ack before a fault.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 change_valid  input  1  one-cycle pulse from vending_machine (its done) qualifying change_in.
REQ-006 change_in  input  8  change amount to pay out, in money units.
REQ-007 coin_empty  input  4  per-denomination hopper-empty flags, indexed by coin code.
REQ-008 coin_ack  input  1  one-cycle pulse from the hopper: the requested coin was ejected.
REQ-009 fault_clr  input  1  clears a latched fault.
REQ-010 coin_req  output  1  request to eject one coin of denomination coin_sel.
REQ-011 coin_sel  output  2  coin code: 00=1, 01=5, 10=10, 11=20 units.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 dispense_done  output  1  one-cycle pulse when the full amount has been paid.
REQ-014 remaining  output  8  amount still owed; after a fault, the shortfall.
REQ-015 fault  output  1  latched fault indicator.
REQ-016 fault_code  output  2  00 none, 01 shortfall, 10 ack timeout, 11 over-range.

Function
REQ-017 States: IDLE, SELECT, REQ, DONE, FAULT.
REQ-018 IDLE: change_valid with change_in <= MAX_CHANGE loads remaining and goes to SELECT.
REQ-019 IDLE: change_valid with change_in > MAX_CHANGE goes to FAULT with code 11 and remaining=change_in.
REQ-020 change_valid outside IDLE is ignored; remaining is not disturbed.
REQ-021 SELECT, remaining==0: go to DONE.
REQ-022 SELECT, otherwise: pick the largest denomination d with d <= remaining and coin_empty[d]==0, register it on coin_sel and go to REQ.
REQ-023 SELECT, no eligible d: go to FAULT with code 01; remaining holds the shortfall.
REQ-024 REQ: coin_req=1 and coin_sel stable until coin_ack is sampled high.
REQ-025 REQ, on the coin_ack cycle: remaining -= denom(coin_sel), go to SELECT; coin_req is low the next cycle.
REQ-026 coin_ack while coin_req is low is ignored.
REQ-027 REQ: a wait counter clears on entry; after ACK_TIMEOUT cycles without ack, go to FAULT with code 10 and drop coin_req.
REQ-028 coin_ack in the same cycle as the timeout: the ack wins.
REQ-029 DONE: dispense_done=1 for exactly one cycle, then IDLE.
REQ-030 Zero-change latency: change_valid at edge N gives SELECT in cycle N+1 and dispense_done in cycle N+2.
REQ-031 Each coin costs one SELECT cycle plus the REQ cycles up to and including the ack.
REQ-032 FAULT: fault=1 and fault_code held, coin_req=0, busy=1; fault_clr returns to IDLE and clears fault, fault_code and remaining.
REQ-033 Subtraction never underflows; REQ-022 guarantees d <= remaining.
REQ-034 coin_empty is sampled only in SELECT; changes during REQ do not affect the coin in flight.

Reset
REQ-035 Asserting reset_n low at any time, including mid-dispense, forces IDLE immediately.
REQ-036 Reset values: coin_req=0, coin_sel=00, busy=0, dispense_done=0, remaining=0, fault=0, fault_code=00, wait counter=0.
REQ-037 A coin in flight at reset is abandoned and not retried.

Structure
REQ-038 Shared package vm_pkg holds: coin code enum, denomination constant table (1/5/10/20), state enum, fault code enum, MAX_CHANGE default.
REQ-039 One combinational sub-module, coin_picker (inputs remaining and coin_empty; outputs coin code and found flag), implements REQ-022; the FSM, counter and datapath stay in change_dispenser.

Verification
REQ-040 change_in=37, no empties, ack 2 cycles after each req -> coin_sel sequence 20,10,5,1,1; one dispense_done; remaining=0.
REQ-041 change_in=0 -> dispense_done in cycle N+2; coin_req never asserted.
REQ-042 change_in=30 with coin_empty=1100 -> six coins of code 01 (5), then dispense_done.
REQ-043 change_in=7 with coin_empty=0001 -> one 5 coin, then fault=1, fault_code=01, remaining=2; fault_clr -> IDLE with remaining=0.
REQ-044 change_in=10, coin_ack never sent -> fault_code=10 after exactly 16 REQ cycles, coin_req=0; change_in=41 -> fault_code=11 with no coin_req.
REQ-045 reset_n pulsed low mid-REQ -> all outputs at reset values asynchronously; the next change_valid is served normally.
